// File: rtl/pp_exp_max_buffer.sv
// Group buffer for the SD4 MAC alignment stage: collects N (exp, pp) pairs while tracking the
// largest exponent among nonzero-magnitude pps, then replays them in order tagged with that maximum.
module pp_exp_max_buffer #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_exp,
  input  logic [4:0] in_pp,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_exp,
  output logic [4:0] out_exp_max,
  output logic [4:0] out_pp,
  output logic       out_last
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] wr_idx;
  logic [W-1:0] rd_idx;
  logic [4:0]   max_reg;
  logic [9:0]   buffer [N];

  logic in_xfer;
  logic out_xfer;
  logic last_wr;
  logic last_rd;
  logic raise_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && last_wr) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && last_rd) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_wr   = (wr_idx == LAST_IDX);
  assign last_rd   = (rd_idx == LAST_IDX);
  // Zero-magnitude pps (either sign) contribute nothing after alignment, so they must not set the max.
  assign raise_max = in_xfer && (in_pp[3:0] != 4'd0) && (in_exp > max_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      max_reg <= '0;
      for (int i = 0; i < N; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      if (in_xfer) begin
        buffer[wr_idx] <= {in_exp, in_pp};
        if (!last_wr) begin
          wr_idx <= wr_idx + W'(1);
        end
      end
      if (raise_max) begin
        max_reg <= in_exp;
      end
      if (out_xfer) begin
        if (last_rd) begin
          wr_idx  <= '0;
          rd_idx  <= '0;
          max_reg <= '0;
        end else begin
          rd_idx <= rd_idx + W'(1);
        end
      end
    end
  end

  // Outputs are masked outside DRAIN so stale buffer data never appears while filling.
  always_comb begin
    out_exp     = 5'd0;
    out_pp      = 5'd0;
    out_exp_max = 5'd0;
    out_last    = 1'b0;
    if (state == DRAIN) begin
      out_exp     = buffer[rd_idx][9:5];
      out_pp      = buffer[rd_idx][4:0];
      out_exp_max = max_reg;
      out_last    = last_rd;
    end
  end

endmodule

// File: tb/tb_pp_exp_max_buffer.sv
// Scoreboard bench: driver pushes expected outputs per completed group, monitor pops on each output transfer.
`timescale 1ns/1ps
module tb_pp_exp_max_buffer;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_exp = '0;
  logic [4:0] in_pp = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_exp;
  logic [4:0] out_exp_max;
  logic [4:0] out_pp;
  logic       out_last;

  pp_exp_max_buffer #(.N(NB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp), .in_pp(in_pp),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
    .out_exp_max(out_exp_max), .out_pp(out_pp), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] e;
    logic [4:0] pp;
    logic [4:0] mx;
    logic       last;
  } item_t;

  item_t      sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       rand_rdy = 1'b0;
  logic [4:0] g_exp [NB];
  logic [4:0] g_pp  [NB];

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  always @(posedge clk) begin
    #1 out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  logic       prev_stall = 1'b0;
  logic       expect_fill = 1'b0;
  logic [4:0] p_exp, p_pp, p_mx;
  logic       p_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall  = 1'b0;
      expect_fill = 1'b0;
    end else begin
      if (expect_fill) begin
        check("in_ready_after_last", int'(in_ready), 1);
        check("out_valid_after_last", int'(out_valid), 0);
        expect_fill = 1'b0;
      end
      if (out_valid) begin
        check("in_ready_low_in_drain", int'(in_ready), 0);
        if (prev_stall) begin
          check("hold_exp", int'(out_exp), int'(p_exp));
          check("hold_pp", int'(out_pp), int'(p_pp));
          check("hold_max", int'(out_exp_max), int'(p_mx));
          check("hold_last", int'(out_last), int'(p_last));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: exp %0d pp %0d with empty scoreboard", out_exp, out_pp);
          end else begin
            item_t it;
            it = sb.pop_front();
            check("out_exp", int'(out_exp), int'(it.e));
            check("out_pp", int'(out_pp), int'(it.pp));
            check("out_exp_max", int'(out_exp_max), int'(it.mx));
            check("out_last", int'(out_last), int'(it.last));
            if (it.last) expect_fill = 1'b1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      p_exp = out_exp; p_pp = out_pp; p_mx = out_exp_max; p_last = out_last;
    end
  end

  // Called at posedge+1; leaves in_valid high after the accepting edge.
  task automatic send_pair(input logic [4:0] e, input logic [4:0] p);
    int n;
    in_valid = 1'b1;
    in_exp   = e;
    in_pp    = p;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: in_ready 0 expected 1 within budget");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_group(input int gap_max, input bit drop_valid);
    int mx;
    mx = 0;
    for (int i = 0; i < NB; i++) begin
      if (g_pp[i][3:0] != 0 && int'(g_exp[i]) > mx) mx = int'(g_exp[i]);
    end
    for (int i = 0; i < NB; i++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_pair(g_exp[i], g_pp[i]);
    end
    for (int i = 0; i < NB; i++) begin
      item_t it;
      it.e = g_exp[i]; it.pp = g_pp[i]; it.mx = 5'(mx); it.last = (i == NB - 1);
      sb.push_back(it);
    end
    if (drop_valid) in_valid = 1'b0;
    @(negedge clk);
    check("drain_latency_valid", int'(out_valid), 1);
    check("drain_latency_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_complete", sb.size(), 0);
  endtask

  function automatic logic [4:0] rnd_pp(input bit nonzero);
    logic [4:0] p;
    p = 5'($urandom);
    if (nonzero && p[3:0] == 0) p[3:0] = 4'(1 + $urandom_range(0, 14));
    return p;
  endfunction

  initial begin
    #12;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_exp", int'(out_exp), 0);
    check("rst_out_pp", int'(out_pp), 0);
    check("rst_out_exp_max", int'(out_exp_max), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic ordering and max
    g_exp = '{5'd3, 5'd7, 5'd5, 5'd2};
    for (int i = 0; i < NB; i++) g_pp[i] = rnd_pp(1);
    send_group(0, 1);
    wait_drained();

    // Negative zero at exp 20 must not win
    g_exp = '{5'd3, 5'd20, 5'd5, 5'd4};
    for (int i = 0; i < NB; i++) g_pp[i] = rnd_pp(1);
    g_pp[1] = 5'b10000;
    send_group(0, 1);
    wait_drained();

    // No participating entry
    g_exp = '{5'd9, 5'd31, 5'd1, 5'd4};
    for (int i = 0; i < NB; i++) g_pp[i] = {1'($urandom), 4'd0};
    send_group(0, 1);
    wait_drained();

    // Backpressure during drain
    rand_rdy = 1'b1;
    for (int i = 0; i < NB; i++) begin
      g_exp[i] = 5'($urandom);
      g_pp[i]  = rnd_pp(1);
    end
    send_group(0, 1);
    wait_drained();
    rand_rdy = 1'b0;
    idle(2);

    // Reset mid-fill discards the partial group
    send_pair(5'd30, 5'd9);
    send_pair(5'd30, 5'd21);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    g_exp = '{5'd1, 5'd2, 5'd3, 5'd4};
    for (int i = 0; i < NB; i++) g_pp[i] = rnd_pp(1);
    send_group(0, 1);
    wait_drained();

    // in_valid held across two groups
    g_exp = '{5'd1, 5'd2, 5'd3, 5'd4};
    for (int i = 0; i < NB; i++) g_pp[i] = rnd_pp(1);
    send_group(0, 0);
    g_exp = '{5'd8, 5'd7, 5'd6, 5'd5};
    for (int i = 0; i < NB; i++) g_pp[i] = rnd_pp(1);
    send_group(0, 1);
    wait_drained();

    // Random groups with input gaps and random backpressure
    rand_rdy = 1'b1;
    for (int g = 0; g < 20; g++) begin
      for (int i = 0; i < NB; i++) begin
        g_exp[i] = 5'($urandom);
        g_pp[i]  = rnd_pp($urandom_range(0, 3) != 0);
      end
      send_group(2, 1);
    end
    wait_drained();
    rand_rdy = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
